// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, single-slave arbiter for the shared memory port.
// Master 0 is the CPU and master 1 is a secondary requester such as DMA or a
// loader. One access is granted per slot. Writes complete in their grant
// cycle. Reads wait RD_LAT cycles, and then the owner receives registered
// read data.
// Optional build macro MEMARB_BURST_EN: while master 1 holds m1_lock, it keeps
// priority for up to MAX_BURST consecutive grants. Without the macro, m1_lock
// is ignored and arbitration is pure round-robin.
module mem_arbiter #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] IO_BASE   = 32'h0000FF00,
    parameter int               RD_LAT    = 1,
    parameter int               MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_adr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_adr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    input  logic             m1_lock,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             ram_we,
    output logic             io_we,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic [WIDTH-1:0] io_rdata
);

    // state   | meaning
    // S_IDLE  | free slot: a grant may issue this cycle
    // S_RD_WAIT | read outstanding, counting down the slave latency
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RD_WAIT = 1'b1;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    logic [0:0]       state;
    logic             last_owner;
    logic             rd_owner;
    logic             rd_io_sel;
    logic [WIDTH-1:0] rd_adr;
    logic [2:0]       lat_cnt;

    logic             grant_any;
    logic             pick_m1;
    logic             burst_hold;
    logic             win_we;
    logic [WIDTH-1:0] win_adr;
    logic [WIDTH-1:0] win_wdata;
    logic             win_io;

`ifdef MEMARB_BURST_EN
    localparam int BCW = $clog2(MAX_BURST + 1);

    logic [BCW-1:0] burst_cnt;

    // Count consecutive locked grants to master 1. The count clears when the
    // lock or the request drops, or when the MAX_BURST-th grant is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (!(m1_req && m1_lock)) begin
            burst_cnt <= '0;
        end else if (m1_gnt) begin
            if (burst_cnt == BCW'(MAX_BURST - 1))
                burst_cnt <= '0;
            else
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

    assign burst_hold = (burst_cnt != '0) && m1_lock;
`else
    logic unused_lock;

    assign burst_hold  = 1'b0;
    assign unused_lock = m1_lock | (MAX_BURST < 1);
`endif

    // Pick the winner in IDLE: round-robin on a tie, unless a locked burst
    // from master 1 is in progress.
    always_comb begin
        grant_any = 1'b0;
        pick_m1   = 1'b0;
        if (!reset && state == S_IDLE) begin
            grant_any = m0_req | m1_req;
            if (m0_req && m1_req)
                pick_m1 = burst_hold || !last_owner;
            else
                pick_m1 = m1_req;
        end
    end

    // Mux the winning master onto the slave side and decode RAM vs I/O.
    always_comb begin
        win_we    = pick_m1 ? m1_we    : m0_we;
        win_adr   = pick_m1 ? m1_adr   : m0_adr;
        win_wdata = pick_m1 ? m1_wdata : m0_wdata;
        win_io    = (win_adr >= IO_BASE);
    end

    // Drive grants, strobes, and the slave bus. The read address is held for
    // the whole wait, so a slave with a combinational read sees it steadily.
    always_comb begin
        m0_gnt    = grant_any && !pick_m1;
        m1_gnt    = grant_any &&  pick_m1;
        ram_we    = grant_any &&  win_we && !win_io;
        io_we     = grant_any &&  win_we &&  win_io;
        mem_adr   = '0;
        mem_wdata = '0;
        if (grant_any) begin
            mem_adr   = win_adr;
            mem_wdata = win_we ? win_wdata : '0;
        end else if (!reset && state == S_RD_WAIT) begin
            mem_adr   = rd_adr;
        end
    end

    // Sequence reads: latch the owner and decode at grant, count down the
    // latency, then register the return data and pulse the owner's rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            rd_owner   <= 1'b0;
            rd_io_sel  <= 1'b0;
            rd_adr     <= '0;
            lat_cnt    <= '0;
            rdata      <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        last_owner <= pick_m1;
                        if (!win_we) begin
                            rd_owner  <= pick_m1;
                            rd_io_sel <= win_io;
                            rd_adr    <= win_adr;
                            lat_cnt   <= LAT_INIT;
                            state     <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        rdata     <= rd_io_sel ? io_rdata : ram_rdata;
                        m0_rvalid <= !rd_owner;
                        m1_rvalid <=  rd_owner;
                        lat_cnt   <= '0;
                        state     <= S_IDLE;
                    end else begin
                        lat_cnt   <= lat_cnt - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
